// File: rtl/w_pkg.sv
// Shared definitions for the weight fetch/replay stage: bit-width encodings,
// FSM state type and the reads-per-word rule.
package w_pkg;

  localparam logic [2:0] BW_2B = 3'b001;
  localparam logic [2:0] BW_4B = 3'b010;
  localparam logic [2:0] BW_8B = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

  // Unknown encodings replay 4 times, matching the mux's 2-bit pointer wrap.
  function automatic logic [2:0] reads_per_word(input logic [2:0] bw);
    case (bw)
      BW_2B:   return 3'd1;
      BW_4B:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/w_fetch_if.sv
// Streamer-side write handshake and mux-side read strobe of the weight fetch stage.
interface w_fetch_if;

  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        stall;
  logic        rd_en;
  logic [31:0] data_out;

  modport master (
    output wr_valid, wr_data, stall,
    input  wr_ready, rd_en, data_out
  );

  modport slave (
    input  wr_valid, wr_data, stall,
    output wr_ready, rd_en, data_out
  );

endinterface

// File: rtl/w_fifo.sv
// Synchronous 32-bit FIFO with combinational head; no write-to-head pass-through.
module w_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [31:0] wdata_i,
  input  logic        pop_i,
  output logic [31:0] head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/w_fetch.sv
// Weight fetch/replay stage: buffers streamer words and replays each one
// 1/2/4 times into the sub-word mux, one tile of num_words per start.
module w_fetch
  import w_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [2:0]       input_bitwidth,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  w_fetch_if.slave         wbus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] zero_cnt
);

  fetch_state_t     state_q, state_d;
  logic [2:0]       bw_q, bw_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [1:0]       sub_q, sub_d;

  logic        push, pop, full, empty, wr_ready, rd_en, last_sub;
  logic [31:0] head;
  logic [2:0]  rpw;

  w_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (RST),
    .push_i  (push),
    .wdata_i (wbus.wr_data),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign rpw      = reads_per_word(bw_q);
  assign last_sub = (3'(sub_q) == rpw - 3'd1);
  assign wr_ready = (state_q == RUN) && !full && (acc_q < num_q);
  assign rd_en    = (state_q == RUN) && !empty && !wbus.stall;
  assign push     = wbus.wr_valid && wr_ready;
  assign pop      = rd_en && last_sub;

  always_comb begin
    state_d   = state_q;
    bw_d      = bw_q;
    num_d     = num_q;
    acc_d     = acc_q;
    pop_cnt_d = pop_cnt_q;
    zero_d    = zero_q;
    sub_d     = sub_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bw_d      = input_bitwidth;
          num_d     = num_words;
          acc_d     = '0;
          pop_cnt_d = '0;
          zero_d    = '0;
          state_d   = (num_words != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (push) acc_d = acc_q + CNT_W'(1);
        if (rd_en) sub_d = last_sub ? 2'd0 : sub_q + 2'd1;
        if (pop) begin
          pop_cnt_d = pop_cnt_q + CNT_W'(1);
          if (head == '0 && zero_q != '1) zero_d = zero_q + CNT_W'(1);
          // Tile ends only on the final sub-read of the last word.
          if (pop_cnt_q + CNT_W'(1) == num_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      bw_q      <= BW_8B;
      num_q     <= '0;
      acc_q     <= '0;
      pop_cnt_q <= '0;
      zero_q    <= '0;
      sub_q     <= '0;
    end else begin
      state_q   <= state_d;
      bw_q      <= bw_d;
      num_q     <= num_d;
      acc_q     <= acc_d;
      pop_cnt_q <= pop_cnt_d;
      zero_q    <= zero_d;
      sub_q     <= sub_d;
    end
  end

  assign wbus.wr_ready = wr_ready;
  assign wbus.rd_en    = rd_en;
  assign wbus.data_out = empty ? '0 : head;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign zero_cnt      = zero_q;

endmodule

// File: tb/tb_w_fetch.sv
// Scoreboard bench for w_fetch: each tile's expected read stream and done
// summary are queued up front and checked by an independent monitor.
module tb_w_fetch;
  import w_pkg::*;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    int unsigned zc;
    int unsigned n;
    int          cycles;
  } tile_t;

  logic        clk = 1'b0;
  logic        RST;
  logic [2:0]  input_bitwidth;
  logic        start;
  logic [15:0] num_words;
  logic        busy, done;
  logic [15:0] zero_cnt;

  w_fetch_if wbus();

  w_fetch #(.DEPTH(4), .CNT_W(16)) dut (
    .clk            (clk),
    .RST            (RST),
    .input_bitwidth (input_bitwidth),
    .start          (start),
    .num_words      (num_words),
    .wbus           (wbus),
    .busy           (busy),
    .done           (done),
    .zero_cnt       (zero_cnt)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0;
  int unsigned stall_pct = 0, valid_pct = 100;
  int unsigned acc_total = 0, done_cnt = 0, rd_total = 0;
  logic [31:0] exp_data[$];
  logic [31:0] stream_q[$];
  tile_t       exp_done[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int unsigned model_reads(input logic [2:0] bw);
    if (bw == 3'b001) return 1;
    if (bw == 3'b010) return 2;
    return 4;
  endfunction

  // Streamer and back-pressure driver.
  initial begin
    bit acc = 1'b0;
    wbus.wr_valid = 1'b0;
    wbus.wr_data  = '0;
    wbus.stall    = 1'b0;
    forever begin
      @(negedge clk);
      if (acc && stream_q.size() > 0) void'(stream_q.pop_front());
      wbus.stall    = ($urandom_range(99) < stall_pct);
      wbus.wr_valid = (stream_q.size() > 0) && ($urandom_range(99) < valid_pct);
      wbus.wr_data  = (stream_q.size() > 0) ? stream_q[0] : 32'h0;
      #2;
      acc = wbus.wr_valid && wbus.wr_ready && !RST;
      if (acc) acc_total++;
    end
  end

  // Monitor: compares every read and every done against the queued expectations.
  initial begin
    int unsigned busy_cnt = 0;
    bit prev_rd = 1'b0;
    tile_t t;
    forever begin
      @(negedge clk);
      #2;
      if (RST) begin
        busy_cnt = 0;
        prev_rd  = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (wbus.stall && busy) check("stall_blocks_rd", 32'(wbus.rd_en), 32'h0);
        if (!busy) begin
          check("idle_data_out", wbus.data_out, 32'h0);
          check("idle_strobes", {30'b0, wbus.rd_en, wbus.wr_ready}, 32'h0);
        end
        if (wbus.rd_en) begin
          rd_total++;
          if (exp_data.size() == 0) fail_now("unexpected_rd");
          else check("rd_data", wbus.data_out, exp_data.pop_front());
        end
        if (done) begin
          done_cnt++;
          if (exp_done.size() == 0) fail_now("unexpected_done");
          else begin
            t = exp_done.pop_front();
            check("zero_cnt", 32'(zero_cnt), t.zc);
            check("reads_left", exp_data.size(), 32'h0);
            check("done_after_last_rd", 32'(prev_rd), 32'(t.n != 0));
            if (t.cycles >= 0) check("tile_cycles", busy_cnt, t.cycles);
          end
          busy_cnt = 0;
        end
        prev_rd = wbus.rd_en;
      end
    end
  end

  task automatic start_tile(input logic [2:0] bw, input wq_t words, input int unsigned extra,
                            output int unsigned target);
    int unsigned r = model_reads(bw);
    tile_t t;
    t.zc = 0;
    t.n  = words.size();
    @(negedge clk);
    #3;
    foreach (words[i]) begin
      stream_q.push_back(words[i]);
      repeat (r) exp_data.push_back(words[i]);
      if (words[i] == 32'h0) t.zc++;
    end
    for (int i = 0; i < int'(extra); i++) stream_q.push_back($urandom | 32'h1);
    if (stall_pct == 0 && valid_pct == 100) t.cycles = (t.n == 0) ? 1 : int'(t.n * r + 2);
    else t.cycles = -1;
    exp_done.push_back(t);
    target = done_cnt + 1;
    @(negedge clk);
    input_bitwidth = bw;
    num_words      = 16'(t.n);
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
    input_bitwidth = 3'($urandom);
    num_words      = 16'($urandom);
  endtask

  task automatic finish_tile(input int unsigned target);
    int unsigned k;
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      #3;
      if (done_cnt >= target) break;
    end
    if (k == 2000) fail_now("done_timeout");
    stream_q.delete();
  endtask

  task automatic run_tile(input logic [2:0] bw, input wq_t words, input int unsigned extra,
                          input bit mid_start);
    int unsigned target;
    start_tile(bw, words, extra, target);
    if (mid_start) begin
      @(negedge clk);
      input_bitwidth = BW_2B;
      num_words      = 16'd1;
      start          = 1'b1;
      @(negedge clk);
      start          = 1'b0;
    end
    finish_tile(target);
  endtask

  function automatic wq_t rand_words(input int unsigned n, input int unsigned zero_pct);
    wq_t q;
    for (int i = 0; i < int'(n); i++)
      q.push_back(($urandom_range(99) < zero_pct) ? 32'h0 : ($urandom | 32'h100));
    return q;
  endfunction

  initial begin
    logic [2:0]  bw_opts[6] = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b000, 3'b111};
    int unsigned target, base, k, done_before;

    RST = 1'b1;
    start = 1'b0;
    input_bitwidth = BW_8B;
    num_words = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_wr_ready", 32'(wbus.wr_ready), 32'h0);
    check("rst_rd_en",    32'(wbus.rd_en),    32'h0);
    check("rst_data_out", wbus.data_out,      32'h0);
    check("rst_busy",     32'(busy),          32'h0);
    check("rst_done",     32'(done),          32'h0);
    check("rst_zero_cnt", 32'(zero_cnt),      32'h0);
    @(negedge clk);
    RST = 1'b0;

    run_tile(BW_8B, '{32'h44332211, 32'h88776655}, 0, 1'b0);
    run_tile(BW_4B, rand_words(3, 20), 0, 1'b0);
    run_tile(BW_2B, rand_words(3, 20), 0, 1'b0);
    run_tile(BW_8B, '{32'h0, 32'hA5, 32'h0, 32'h0}, 0, 1'b0);
    run_tile(BW_8B, '{}, 2, 1'b0);
    run_tile(3'b011, rand_words(2, 0), 2, 1'b0);
    run_tile(BW_8B, rand_words(3, 30), 0, 1'b1);

    // FIFO fills to DEPTH under sustained stall, then drains.
    stall_pct = 100;
    acc_total = 0;
    start_tile(BW_8B, rand_words(6, 30), 0, target);
    repeat (10) @(negedge clk);
    #3;
    check("fifo_fill_count", acc_total, 32'd4);
    check("wr_ready_full",   32'(wbus.wr_ready), 32'h0);
    stall_pct = 0;
    finish_tile(target);

    // Reset in the middle of a tile aborts it silently.
    base = rd_total;
    start_tile(BW_8B, '{32'h0, 32'h0, 32'h0}, 0, target);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #3;
      if (rd_total >= base + 6) break;
    end
    if (k == 200) fail_now("reads_timeout");
    done_before = done_cnt;
    @(negedge clk);
    RST = 1'b1;
    #3;
    exp_data.delete();
    exp_done.delete();
    stream_q.delete();
    @(negedge clk);
    RST = 1'b0;
    #3;
    check("abort_busy",     32'(busy),          32'h0);
    check("abort_rd_en",    32'(wbus.rd_en),    32'h0);
    check("abort_data_out", wbus.data_out,      32'h0);
    check("abort_zero_cnt", 32'(zero_cnt),      32'h0);
    check("abort_wr_ready", 32'(wbus.wr_ready), 32'h0);
    repeat (4) @(negedge clk);
    #3;
    check("abort_no_done", done_cnt, done_before);
    run_tile(BW_8B, rand_words(2, 50), 0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      stall_pct = ($urandom_range(2) == 0) ? 0 : $urandom_range(40);
      valid_pct = ($urandom_range(2) == 0) ? 100 : $urandom_range(40, 100);
      run_tile(bw_opts[$urandom_range(5)], rand_words($urandom_range(6), 30),
               $urandom_range(2), 1'b0);
    end
    stall_pct = 0;
    valid_pct = 100;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
